// File: rtl/hms_controller.sv
// Mode/position/edit controller for the HMS clock: debounced buttons, 1 Hz tick
// and carry edges become one-cycle count pulses for the time and alarm counters.
module hms_controller #(
  parameter int CLK_HZ     = 50000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  input  logic       i_sw_alarm,
  input  logic       i_max_hit_sec,
  input  logic       i_max_hit_min,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_alarm_en,
  output logic       o_sec_clk,
  output logic       o_min_clk,
  output logic       o_hour_clk,
  output logic       o_alarm_sec_clk,
  output logic       o_alarm_min_clk,
  output logic       o_alarm_hour_clk
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2,
    MODE_BAD   = 2'd3
  } mode_t;

  localparam logic [1:0] POS_SEC  = 2'd0;
  localparam logic [1:0] POS_MIN  = 2'd1;
  localparam logic [1:0] POS_HOUR = 2'd2;

  // Button order: 0 mode, 1 pos, 2 inc, 3 alarm.
  logic [3:0] btn_raw;
  logic [3:0] press;
  assign btn_raw = {i_sw_alarm, i_sw_inc, i_sw_pos, i_sw_mode};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          deb_reg;
      logic          deb_prev_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          deb_reg      <= 1'b0;
          deb_prev_reg <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync1_reg    <= btn_raw[gi];
          sync2_reg    <= sync1_reg;
          deb_prev_reg <= deb_reg;
          // The flip happens on the DEB_CYCLES-th consecutive differing sample.
          if (sync2_reg != deb_reg) begin
            if (cnt_reg == DEB_LAST) begin
              deb_reg <= sync2_reg;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign press[gi] = deb_reg & ~deb_prev_reg;
    end
  endgenerate

  logic [TW-1:0] tick_cnt_reg;
  logic          tick;
  assign tick = (tick_cnt_reg == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  logic max_sec_prev_reg;
  logic max_min_prev_reg;
  logic sec_rise;
  logic min_rise;
  assign sec_rise = i_max_hit_sec & ~max_sec_prev_reg;
  assign min_rise = i_max_hit_min & ~max_min_prev_reg;

  mode_t      mode_reg, mode_next;
  logic [1:0] pos_reg, pos_next;
  logic       alarm_en_reg, alarm_en_next;
  // Pulse order: sec, min, hour, alarm sec, alarm min, alarm hour.
  logic [5:0] pulse_reg, pulse_next;
  logic       time_run;

  always_comb begin
    mode_next     = mode_reg;
    pos_next      = pos_reg;
    alarm_en_next = alarm_en_reg ^ press[3];
    pulse_next    = '0;
    time_run      = (mode_reg == MODE_CLOCK) || (mode_reg == MODE_ALARM);

    case (mode_reg)
      MODE_CLOCK: if (press[0]) mode_next = MODE_SETUP;
      MODE_SETUP: if (press[0]) mode_next = MODE_ALARM;
      MODE_ALARM: if (press[0]) mode_next = MODE_CLOCK;
      default:    mode_next = MODE_CLOCK;
    endcase

    if (mode_next != mode_reg) begin
      pos_next = POS_SEC;
    end else if (press[1] && (mode_reg != MODE_CLOCK)) begin
      pos_next = (pos_reg >= POS_HOUR) ? POS_SEC : pos_reg + 2'd1;
    end

    pulse_next[0] = tick & time_run;
    pulse_next[1] = sec_rise & time_run;
    pulse_next[2] = min_rise & time_run;

    // SETUP and ALARM never let the tick/carry sources through to the same output.
    if (press[2]) begin
      if (mode_reg == MODE_SETUP) begin
        case (pos_reg)
          POS_SEC:  pulse_next[0] = 1'b1;
          POS_MIN:  pulse_next[1] = 1'b1;
          POS_HOUR: pulse_next[2] = 1'b1;
          default:  ;
        endcase
      end else if (mode_reg == MODE_ALARM) begin
        case (pos_reg)
          POS_SEC:  pulse_next[3] = 1'b1;
          POS_MIN:  pulse_next[4] = 1'b1;
          POS_HOUR: pulse_next[5] = 1'b1;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg         <= MODE_CLOCK;
      pos_reg          <= POS_SEC;
      alarm_en_reg     <= 1'b0;
      pulse_reg        <= '0;
      max_sec_prev_reg <= 1'b0;
      max_min_prev_reg <= 1'b0;
    end else begin
      mode_reg         <= mode_next;
      pos_reg          <= pos_next;
      alarm_en_reg     <= alarm_en_next;
      pulse_reg        <= pulse_next;
      max_sec_prev_reg <= i_max_hit_sec;
      max_min_prev_reg <= i_max_hit_min;
    end
  end

  assign o_mode           = mode_reg;
  assign o_position       = pos_reg;
  assign o_alarm_en       = alarm_en_reg;
  assign o_sec_clk        = pulse_reg[0];
  assign o_min_clk        = pulse_reg[1];
  assign o_hour_clk       = pulse_reg[2];
  assign o_alarm_sec_clk  = pulse_reg[3];
  assign o_alarm_min_clk  = pulse_reg[4];
  assign o_alarm_hour_clk = pulse_reg[5];

endmodule

// File: tb/tb_hms_controller.sv
// Bench for hms_controller: directed steps from the test plan plus a random phase,
// every cycle compared against a behavioural model of the controller.
module tb_hms_controller;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'b0;  // 0 mode, 1 pos, 2 inc, 3 alarm
  logic       max_sec = 1'b0;
  logic       max_min = 1'b0;
  logic [1:0] o_mode, o_position;
  logic       o_alarm_en, o_sec_clk, o_min_clk, o_hour_clk;
  logic       o_alarm_sec_clk, o_alarm_min_clk, o_alarm_hour_clk;

  hms_controller #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sw_mode(sw[0]), .i_sw_pos(sw[1]), .i_sw_inc(sw[2]), .i_sw_alarm(sw[3]),
    .i_max_hit_sec(max_sec), .i_max_hit_min(max_min),
    .o_mode(o_mode), .o_position(o_position), .o_alarm_en(o_alarm_en),
    .o_sec_clk(o_sec_clk), .o_min_clk(o_min_clk), .o_hour_clk(o_hour_clk),
    .o_alarm_sec_clk(o_alarm_sec_clk), .o_alarm_min_clk(o_alarm_min_clk),
    .o_alarm_hour_clk(o_alarm_hour_clk)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int pcnt[6];

  // Behavioural model: a button level is accepted after DEB consecutive
  // synchronised samples disagree with it; a rising acceptance acts one edge later.
  int       m_mode, m_pos, m_cycles;
  bit       m_en;
  bit [5:0] m_pulse;
  bit       hist1[4], hist2[4], deb[4], pend[4];
  int       run_len[4];
  bit       cprev_s, cprev_m;

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_cycles = 0; m_en = 0; m_pulse = '0;
    cprev_s = 0; cprev_m = 0;
    for (int b = 0; b < 4; b++) begin
      hist1[b] = 0; hist2[b] = 0; deb[b] = 0; pend[b] = 0; run_len[b] = 0;
    end
  endfunction

  function automatic void model_edge(bit [3:0] raw, bit cs, bit cm);
    int mode0 = m_mode;
    int pos0 = m_pos;
    bit running = (m_mode != 1);
    bit s;
    m_cycles++;
    m_pulse = '0;
    m_pulse[0] = ((m_cycles % CLK_HZ) == 0) && running;
    m_pulse[1] = cs && !cprev_s && running;
    m_pulse[2] = cm && !cprev_m && running;
    cprev_s = cs;
    cprev_m = cm;
    if (pend[0]) begin
      m_mode = (mode0 + 1) % 3;
      m_pos = 0;
    end else if (pend[1] && mode0 != 0) begin
      m_pos = (pos0 + 1) % 3;
    end
    if (pend[2]) begin
      if (mode0 == 1) m_pulse[pos0] = 1'b1;
      else if (mode0 == 2) m_pulse[3 + pos0] = 1'b1;
    end
    if (pend[3]) m_en = !m_en;
    for (int b = 0; b < 4; b++) begin
      s = hist2[b];
      hist2[b] = hist1[b];
      hist1[b] = raw[b];
      pend[b] = 0;
      if (s != deb[b]) begin
        run_len[b]++;
        if (run_len[b] == DEB) begin
          deb[b] = s;
          run_len[b] = 0;
          pend[b] = s;
        end
      end else begin
        run_len[b] = 0;
      end
    end
  endfunction

  function automatic logic [10:0] got_vec();
    return {o_mode, o_position, o_alarm_en, o_alarm_hour_clk, o_alarm_min_clk,
            o_alarm_sec_clk, o_hour_clk, o_min_clk, o_sec_clk};
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [31:0] mm = m_mode;
    logic [31:0] mp = m_pos;
    return {mm[1:0], mp[1:0], m_en, m_pulse};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic step();
    logic [5:0] p;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(sw, max_sec, max_min);
    #1;
    chk("cycle", got_vec(), exp_vec());
    p = {o_alarm_hour_clk, o_alarm_min_clk, o_alarm_sec_clk, o_hour_clk, o_min_clk, o_sec_clk};
    for (int i = 0; i < 6; i++) pcnt[i] += p[i];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    for (int i = 0; i < 6; i++) pcnt[i] = 0;
  endtask

  task automatic press(input int b, input int hold);
    sw[b] = 1'b1;
    run(hold);
    sw[b] = 1'b0;
    run(10);
  endtask

  // Returns the edge (1-based) at which mode/position/enable first changed.
  task automatic press_lat(input int b, input int hold, output int lat);
    logic [4:0] sig0 = {o_mode, o_position, o_alarm_en};
    lat = 0;
    sw[b] = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      step();
      if (lat == 0 && {o_mode, o_position, o_alarm_en} != sig0) lat = i;
    end
    sw[b] = 1'b0;
    run(10);
  endtask

  int lat;
  int rem[4];

  initial begin
    clr();
    model_reset();
    run(2);
    @(negedge clk);
    chk("reset_outputs", got_vec(), 11'd0);
    rst_n = 1'b1;

    // Free-running tick only
    clr();
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i % 10 == 0) chk("tick_pulse", o_sec_clk, 1);
    end
    chk("tick_count", pcnt[0], 3);
    chk("idle_others", pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4] + pcnt[5], 0);

    // Carries in CLOCK
    clr();
    max_sec = 1'b1;
    step();
    chk("min_pulse_next", o_min_clk, 1);
    run(9);
    max_sec = 1'b0;
    max_min = 1'b1;
    step();
    chk("hour_pulse_next", o_hour_clk, 1);
    run(9);
    max_min = 1'b0;
    run(2);
    chk("min_count", pcnt[1], 1);
    chk("hour_count", pcnt[2], 1);

    // CLOCK -> SETUP
    press_lat(0, 10, lat);
    chk("mode_lat_1", lat, 7);
    chk("mode_setup", o_mode, 1);

    // SETUP: carries and tick suppressed
    clr();
    max_sec = 1'b1; run(10); max_sec = 1'b0;
    max_min = 1'b1; run(10); max_min = 1'b0;
    run(12);
    chk("setup_no_carry", pcnt[1] + pcnt[2], 0);
    chk("setup_frozen", pcnt[0], 0);

    // SETUP: pos twice then inc
    clr();
    press(1, 6);
    press(1, 6);
    chk("setup_pos_hour", o_position, 2);
    press(2, 6);
    chk("setup_inc_hour", pcnt[2], 1);
    chk("setup_no_alarm_hour", pcnt[5], 0);
    chk("setup_frozen_2", pcnt[0], 0);

    // Bouncing inc, then stable: one event
    clr();
    for (int i = 0; i < 10; i++) begin
      sw[2] = ~sw[2];
      run(2);
    end
    sw[2] = 1'b1;
    run(10);
    sw[2] = 1'b0;
    run(10);
    chk("bounce_one_event", pcnt[2], 1);

    // SETUP -> ALARM
    press_lat(0, 10, lat);
    chk("mode_lat_2", lat, 7);
    chk("mode_alarm", o_mode, 2);
    chk("alarm_pos_sec", o_position, 0);
    press(1, 6);
    chk("alarm_pos_min", o_position, 1);
    clr();
    press(2, 6);
    chk("alarm_inc_min", pcnt[4], 1);
    chk("alarm_no_time_min", pcnt[1], 0);
    clr();
    run(30);
    chk("alarm_tick_runs", pcnt[0], 3);
    press(3, 6);
    chk("alarm_en_on", o_alarm_en, 1);
    press(3, 6);
    chk("alarm_en_off", o_alarm_en, 0);

    // Position HOUR, then mode press forces SEC
    press(1, 6);
    chk("alarm_pos_hour", o_position, 2);
    press_lat(0, 10, lat);
    chk("mode_lat_3", lat, 7);
    chk("mode_clock", o_mode, 0);
    chk("mode_forces_sec", o_position, 0);

    // Simultaneous mode+pos in CLOCK: mode wins for position
    sw = 4'b0011;
    run(10);
    sw = 4'b0000;
    run(10);
    chk("simul_mode", o_mode, 1);
    chk("simul_pos", o_position, 0);

    // Reset in the middle of a stable press
    sw[2] = 1'b1;
    run(2);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset", got_vec(), 11'd0);
    sw[2] = 1'b0;
    run(2);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    run(9);
    chk("no_pending_after_reset", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4] + pcnt[5], 0);
    chk("state_after_reset", {o_mode, o_position, o_alarm_en}, 5'd0);
    press_lat(0, 10, lat);
    chk("fresh_press_lat", lat, 7);

    // Random phase against the model
    for (int b = 0; b < 4; b++) rem[b] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (rem[b] == 0) begin
          sw[b] = ($urandom_range(0, 2) == 0);
          rem[b] = $urandom_range(1, 12);
        end else begin
          rem[b]--;
        end
      end
      if ($urandom_range(0, 7) == 0) max_sec = ~max_sec;
      if ($urandom_range(0, 7) == 0) max_min = ~max_min;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hms_controller.md
# hms_controller

Mode/position/edit controller for the HMS clock. It turns four raw push-buttons, a free-running 1 Hz tick and the sec/min carry flags into one-cycle count pulses for the six HMS counters: time sec/min/hour and alarm sec/min/hour. It also holds the display mode, the edit position and the alarm enable consumed by the hourminsec mux/alarm logic. Single clock domain; every output is a registered signal on clk.

## Interface

**Parameters**

- CLK_HZ, 50000000, clk cycles per 1 Hz tick.
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a button level change.

**Ports**

- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_sw_mode  in  1  raw button, active-high; cycles mode.
- i_sw_pos  in  1  raw button, active-high; cycles edit position.
- i_sw_inc  in  1  raw button, active-high; increments the selected field.
- i_sw_alarm  in  1  raw button, active-high; toggles alarm enable.
- i_max_hit_sec  in  1  carry flag from the time-sec counter.
- i_max_hit_min  in  1  carry flag from the time-min counter.
- o_mode  out  2  0 CLOCK, 1 SETUP, 2 ALARM.
- o_position  out  2  0 SEC, 1 MIN, 2 HOUR.
- o_alarm_en  out  1  alarm enable.
- o_sec_clk, o_min_clk, o_hour_clk  out  1 each  time counter pulses.
- o_alarm_sec_clk, o_alarm_min_clk, o_alarm_hour_clk  out  1 each  alarm counter pulses.

## Operation

**Reset values**
- o_mode=0, o_position=0, o_alarm_en=0.
- All pulse outputs 0.
- Tick counter, debounce counters, debounced states and edge registers all 0.

**Button front end** (one per button)
- 2-flop synchronizer.
- Debounce counter increments while the synced level differs from the debounced state and clears otherwise.
- When the counter reaches DEB_CYCLES, the debounced state flips and the counter clears.
- A 0->1 flip of the debounced state produces a one-cycle press event. A 1->0 flip produces no event.

**Mode FSM** (CLOCK -> SETUP -> ALARM -> CLOCK)
- Advances on a mode press.
- Every mode change forces o_position=SEC.
- Value 3 is unreachable; if it is ever seen, the next edge goes to CLOCK.

**Position** (SEC -> MIN -> HOUR -> SEC)
- Advances on a pos press only in SETUP or ALARM; ignored in CLOCK.

**Increment press**
- SETUP: one pulse on the time output selected by o_position.
- ALARM: one pulse on the alarm output selected by o_position.
- CLOCK: ignored.

**Alarm press**
- Toggles o_alarm_en in any mode.

**Tick**
- Counter runs 0..CLK_HZ-1, wraps, and raises tick when at CLK_HZ-1.
- The counter is never stopped or cleared by mode changes.
- o_sec_clk pulses on tick in CLOCK and ALARM. Suppressed in SETUP, so time is frozen while editing.

**Carries**
- A 0->1 edge of i_max_hit_sec pulses o_min_clk.
- A 0->1 edge of i_max_hit_min pulses o_hour_clk.
- Both only in CLOCK and ALARM. Suppressed in SETUP, so manual wraps do not ripple.

## Timing

- All gating decisions use the o_mode/o_position values held before the edge. An event and a mode change in the same cycle act on the old mode.
- Raw button rise, held stable -> o_mode/o_position/o_alarm_en change or count pulse at exactly DEB_CYCLES+3 edges after the first sampled-high edge.
- Tick -> o_sec_clk high for exactly 1 cycle, on the edge after the tick counter reaches CLK_HZ-1. First pulse is CLK_HZ cycles after reset release.
- Carry input edge -> output pulse 1 cycle later, width 1. A held-high carry gives exactly one pulse.
- Every pulse output is high for at most 1 consecutive cycle.
- No two time pulse outputs come from the same source in one cycle. Tick and carry pulses may coincide with each other (different outputs).
- Increment pulses never coincide with a tick or carry on the same output, because the mode gating is exclusive.
- Simultaneous presses on different buttons are all applied in the same cycle. Mode has priority for o_position: a mode press forces SEC regardless of a pos press.
- Reset asserted mid-debounce or mid-pulse: outputs clear immediately. No pending event survives reset release.

## Test plan

Bench parameters: CLK_HZ=10, DEB_CYCLES=4.

1. Reset release, no buttons -> o_sec_clk single-cycle pulses at cycles 10, 20, 30. All other outputs remain 0.
2. CLOCK mode, i_max_hit_sec high for 10 cycles -> exactly one o_min_clk pulse, 1 cycle after the rise. Same stimulus in SETUP -> no pulse. i_max_hit_min the same way -> o_hour_clk.
3. Three mode presses, each 10 cycles high -> o_mode 1, 2, 0, each change 7 cycles after its press. Preset o_position=2 in ALARM; the next mode press -> o_position 0.
4. SETUP: two pos presses -> o_position 2. Inc press -> one o_hour_clk pulse, no o_alarm_hour_clk. No o_sec_clk pulses over 30 cycles.
5. ALARM, position MIN: inc press -> one o_alarm_min_clk pulse while o_sec_clk keeps pulsing every 10 cycles. Alarm press -> o_alarm_en=1; a second press -> 0.
6. Raw inc toggling every 2 cycles for 20 cycles, then stable high -> exactly one increment event. Assert rst_n 2 cycles into a stable press -> all outputs 0 and no pulse after release until a fresh press.
